queue_op_initiator: RTL and testbench

- Requester-side engine for the four-operation req/cpl deque interface: enq_back, enq_front, deq_front, deq_back.
- Accepts one command at a time from an upstream valid/ready port and drives exactly one queue req line until its cpl arrives.
- Returns a response (dequeued data or enqueue ack) on a downstream valid/ready port.
- Sits between a client (core, DMA, test sequencer) and the queue top; tracks occupancy and flags timeouts and protocol errors.

---
 rtl/queue_op_initiator.sv | 165 ++++++++++++++++
 tb/tb_queue_op_initiator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_op_initiator.sv
// Requester-side engine for a four-operation req/cpl deque: takes one command at a
// time, drives the matching req line until cpl or timeout, and returns a response.
module queue_op_initiator #(
  parameter int unsigned p_bitwidth = 32,
  parameter int unsigned p_depth    = 32,
  parameter int unsigned p_timeout  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic [1:0]              cmd_op,
  input  logic [p_bitwidth-1:0]   cmd_data,
  output logic                    rsp_val,
  input  logic                    rsp_rdy,
  output logic [1:0]              rsp_op,
  output logic [p_bitwidth-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    enq_back_req,
  output logic                    enq_front_req,
  output logic                    deq_front_req,
  output logic                    deq_back_req,
  input  logic                    enq_back_cpl,
  input  logic                    enq_front_cpl,
  input  logic                    deq_front_cpl,
  input  logic                    deq_back_cpl,
  output logic [p_bitwidth-1:0]   enq_back_data,
  output logic [p_bitwidth-1:0]   enq_front_data,
  input  logic [p_bitwidth-1:0]   deq_front_data,
  input  logic [p_bitwidth-1:0]   deq_back_data,
  output logic [$clog2(p_depth):0] occupancy,
  output logic                    proto_err
);

  localparam int unsigned OCC_W = $clog2(p_depth) + 1;
  localparam int unsigned CNT_W = $clog2(p_timeout);
  localparam logic [1:0]  OP_ENQ_BACK  = 2'd0;
  localparam logic [1:0]  OP_ENQ_FRONT = 2'd1;
  localparam logic [1:0]  OP_DEQ_FRONT = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [3:0]              req_q, req_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cmd_rdy_d, rsp_val_d, rsp_err_d, proto_err_d;
  logic [1:0]              rsp_op_d;
  logic [p_bitwidth-1:0]   rsp_data_d, enq_back_data_d, enq_front_data_d;
  logic [OCC_W-1:0]        occupancy_d;
  logic [3:0]              cpl_vec, cpl_expected;
  logic [p_bitwidth-1:0]   deq_sel;

  // Bit order of req/cpl vectors follows the op encoding.
  assign cpl_vec       = {deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
  assign deq_sel       = (op_q == OP_DEQ_FRONT) ? deq_front_data : deq_back_data;
  assign enq_back_req  = req_q[0];
  assign enq_front_req = req_q[1];
  assign deq_front_req = req_q[2];
  assign deq_back_req  = req_q[3];

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    req_d            = req_q;
    cnt_d            = cnt_q;
    cmd_rdy_d        = cmd_rdy;
    rsp_val_d        = rsp_val;
    rsp_op_d         = rsp_op;
    rsp_data_d       = rsp_data;
    rsp_err_d        = rsp_err;
    enq_back_data_d  = enq_back_data;
    enq_front_data_d = enq_front_data;
    occupancy_d      = occupancy;
    cpl_expected     = 4'b0000;

    case (state_q)
      IDLE: begin
        cmd_rdy_d = 1'b1;
        if (cmd_val && cmd_rdy) begin
          op_d      = cmd_op;
          cnt_d     = '0;
          req_d     = 4'b0001 << cmd_op;
          cmd_rdy_d = 1'b0;
          state_d   = ISSUE;
          if (cmd_op == OP_ENQ_BACK)  enq_back_data_d  = cmd_data;
          if (cmd_op == OP_ENQ_FRONT) enq_front_data_d = cmd_data;
        end
      end
      ISSUE: begin
        cpl_expected = req_q;
        if (|(cpl_vec & req_q)) begin
          req_d      = 4'b0000;
          rsp_val_d  = 1'b1;
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b0;
          rsp_data_d = op_q[1] ? deq_sel : '0;
          state_d    = RESP;
          // Dequeues carry op[1]; both directions saturate.
          if (!op_q[1] && occupancy != OCC_W'(p_depth)) occupancy_d = occupancy + OCC_W'(1);
          if (op_q[1] && occupancy != '0)               occupancy_d = occupancy - OCC_W'(1);
        end else if (cnt_q == CNT_W'(p_timeout - 1)) begin
          req_d      = 4'b0000;
          rsp_val_d  = 1'b1;
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          rsp_val_d = 1'b0;
          cmd_rdy_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        req_d     = 4'b0000;
        rsp_val_d = 1'b0;
        cmd_rdy_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    proto_err_d = proto_err | (|(cpl_vec & ~cpl_expected));
  end

  // All state and outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      op_q           <= 2'd0;
      req_q          <= 4'b0000;
      cnt_q          <= '0;
      cmd_rdy        <= 1'b0;
      rsp_val        <= 1'b0;
      rsp_op         <= 2'd0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      enq_back_data  <= '0;
      enq_front_data <= '0;
      occupancy      <= '0;
      proto_err      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      cmd_rdy        <= cmd_rdy_d;
      rsp_val        <= rsp_val_d;
      rsp_op         <= rsp_op_d;
      rsp_data       <= rsp_data_d;
      rsp_err        <= rsp_err_d;
      enq_back_data  <= enq_back_data_d;
      enq_front_data <= enq_front_data_d;
      occupancy      <= occupancy_d;
      proto_err      <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_queue_op_initiator.sv
// Directed bench for queue_op_initiator: each task drives one scenario and checks
// hand-computed expectations inline.
module tb_queue_op_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_val, cmd_rdy;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_val, rsp_rdy;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        enq_back_req, enq_front_req, deq_front_req, deq_back_req;
  logic        enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl;
  logic [31:0] enq_back_data, enq_front_data, deq_front_data, deq_back_data;
  logic [5:0]  occupancy;
  logic        proto_err;

  int vectors;
  int miscompares;

  queue_op_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enq_back_req(enq_back_req), .enq_front_req(enq_front_req),
    .deq_front_req(deq_front_req), .deq_back_req(deq_back_req),
    .enq_back_cpl(enq_back_cpl), .enq_front_cpl(enq_front_cpl),
    .deq_front_cpl(deq_front_cpl), .deq_back_cpl(deq_back_cpl),
    .enq_back_data(enq_back_data), .enq_front_data(enq_front_data),
    .deq_front_data(deq_front_data), .deq_back_data(deq_back_data),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] reqs();
    return {deq_back_req, deq_front_req, enq_front_req, enq_back_req};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; caller ensures cmd_rdy is high.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] d);
    cmd_val  = 1'b1;
    cmd_op   = op;
    cmd_data = d;
    tick();
    cmd_val  = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    vectors++; if ({reqs(), rsp_val, rsp_err, proto_err} !== 7'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0", {reqs(), rsp_val, rsp_err, proto_err}); end
    vectors++; if ({occupancy, rsp_op, rsp_data, enq_back_data, enq_front_data} !== '0) begin miscompares++; $display("FAIL reset_data: occ %0d rsp_data %h", occupancy, rsp_data); end
    tick();
    tick();
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_hold_cmd_rdy: got %b want 0", cmd_rdy); end
    rst = 1'b1;
    tick();
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_release_cmd_rdy: got %b want 1", cmd_rdy); end
  endtask

  task automatic test_enq_back();
    send_cmd(2'd0, 32'hA5A5_0001);
    vectors++; if (reqs() !== 4'b0001) begin miscompares++; $display("FAIL enq_back_req_c1: got %b want 0001", reqs()); end
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL enq_back_cmd_rdy: got %b want 0", cmd_rdy); end
    vectors++; if (enq_back_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL enq_back_data: got %h want a5a50001", enq_back_data); end
    tick();
    vectors++; if (reqs() !== 4'b0001) begin miscompares++; $display("FAIL enq_back_req_c2: got %b want 0001", reqs()); end
    enq_back_cpl = 1'b1;
    tick();
    enq_back_cpl = 1'b0;
    vectors++; if (reqs() !== 4'b0000) begin miscompares++; $display("FAIL enq_back_req_drop: got %b want 0000", reqs()); end
    vectors++; if ({rsp_val, rsp_op, rsp_err} !== 4'b1000 || rsp_data !== 32'h0) begin miscompares++; $display("FAIL enq_back_rsp: val %b op %0d err %b data %h want 1 0 0 0", rsp_val, rsp_op, rsp_err, rsp_data); end
    vectors++; if (occupancy !== 6'd1) begin miscompares++; $display("FAIL enq_back_occ: got %0d want 1", occupancy); end
    tick();
    vectors++; if ({rsp_val, cmd_rdy} !== 2'b01) begin miscompares++; $display("FAIL enq_back_handshake: val/rdy %b want 01", {rsp_val, cmd_rdy}); end
  endtask

  task automatic test_deq_front();
    send_cmd(2'd2, 32'hFFFF_FFFF);
    vectors++; if (reqs() !== 4'b0100) begin miscompares++; $display("FAIL deq_front_req: got %b want 0100", reqs()); end
    deq_front_cpl  = 1'b1;
    deq_front_data = 32'hA5A5_0001;
    tick();
    deq_front_cpl  = 1'b0;
    deq_front_data = 32'h0;
    vectors++; if (reqs() !== 4'b0000) begin miscompares++; $display("FAIL deq_front_req_drop: got %b want 0000", reqs()); end
    vectors++; if ({rsp_val, rsp_op, rsp_err} !== 4'b1100 || rsp_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL deq_front_rsp: val %b op %0d err %b data %h want 1 2 0 a5a50001", rsp_val, rsp_op, rsp_err, rsp_data); end
    vectors++; if (occupancy !== 6'd0 || proto_err !== 1'b0) begin miscompares++; $display("FAIL deq_front_occ: occ %0d perr %b want 0 0", occupancy, proto_err); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    send_cmd(2'd1, 32'h0000_BEEF);
    enq_front_cpl = 1'b1;
    tick();
    enq_front_cpl = 1'b0;
    vectors++; if (occupancy !== 6'd1) begin miscompares++; $display("FAIL timeout_pre_occ: got %0d want 1", occupancy); end
    tick();
    send_cmd(2'd3, 32'h0);
    n = 0;
    while (deq_back_req === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    vectors++; if (n !== 64) begin miscompares++; $display("FAIL timeout_req_cycles: got %0d want 64", n); end
    vectors++; if ({rsp_val, rsp_op, rsp_err} !== 4'b1111 || rsp_data !== 32'h0) begin miscompares++; $display("FAIL timeout_rsp: val %b op %0d err %b data %h want 1 3 1 0", rsp_val, rsp_op, rsp_err, rsp_data); end
    vectors++; if (occupancy !== 6'd1) begin miscompares++; $display("FAIL timeout_occ: got %0d want 1", occupancy); end
    tick();
  endtask

  task automatic test_proto_err();
    enq_front_cpl = 1'b1;
    tick();
    enq_front_cpl = 1'b0;
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
    vectors++; if (occupancy !== 6'd1) begin miscompares++; $display("FAIL proto_err_occ: got %0d want 1", occupancy); end
    tick();
    tick();
    send_cmd(2'd2, 32'h0);
    deq_front_cpl  = 1'b1;
    deq_front_data = 32'h1234_5678;
    tick();
    deq_front_cpl  = 1'b0;
    deq_front_data = 32'h0;
    vectors++; if ({rsp_val, rsp_op, rsp_err} !== 4'b1100 || rsp_data !== 32'h1234_5678) begin miscompares++; $display("FAIL proto_err_next_rsp: val %b op %0d err %b data %h want 1 2 0 12345678", rsp_val, rsp_op, rsp_err, rsp_data); end
    vectors++; if (proto_err !== 1'b1 || occupancy !== 6'd0) begin miscompares++; $display("FAIL proto_err_sticky: perr %b occ %0d want 1 0", proto_err, occupancy); end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_rdy = 1'b0;
    send_cmd(2'd3, 32'h0);
    deq_back_cpl  = 1'b1;
    deq_back_data = 32'hCAFE_F00D;
    tick();
    deq_back_cpl  = 1'b0;
    deq_back_data = 32'h1111_2222;
    cmd_val  = 1'b1;
    cmd_op   = 2'd0;
    cmd_data = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({rsp_val, rsp_op, rsp_err, cmd_rdy} !== 5'b11100 || rsp_data !== 32'hCAFE_F00D || reqs() !== 4'b0000) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: val %b op %0d err %b rdy %b data %h req %b", i, rsp_val, rsp_op, rsp_err, cmd_rdy, rsp_data, reqs());
      end
      tick();
    end
    vectors++; if (occupancy !== 6'd0) begin miscompares++; $display("FAIL backpressure_occ_floor: got %0d want 0", occupancy); end
    cmd_val = 1'b0;
    rsp_rdy = 1'b1;
    tick();
    vectors++; if ({rsp_val, cmd_rdy} !== 2'b01) begin miscompares++; $display("FAIL backpressure_release: val/rdy %b want 01", {rsp_val, cmd_rdy}); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 33; k++) begin
      vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_cmd_rdy[%0d]: got %b want 1", k, cmd_rdy); end
      send_cmd(2'd0, 32'(k));
      enq_back_cpl = 1'b1;
      tick();
      enq_back_cpl = 1'b0;
      tick();
    end
    vectors++; if (occupancy !== 6'd32) begin miscompares++; $display("FAIL b2b_occ_ceiling: got %0d want 32", occupancy); end
    send_cmd(2'd3, 32'h0);
    deq_back_cpl = 1'b1;
    tick();
    deq_back_cpl = 1'b0;
    vectors++; if (occupancy !== 6'd31) begin miscompares++; $display("FAIL b2b_occ_after_deq: got %0d want 31", occupancy); end
    tick();
  endtask

  task automatic test_reset_mid_issue();
    send_cmd(2'd1, 32'h7777_0000);
    vectors++; if (reqs() !== 4'b0010) begin miscompares++; $display("FAIL rst_issue_req_pre: got %b want 0010", reqs()); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({reqs(), rsp_val, cmd_rdy} !== 6'b0) begin miscompares++; $display("FAIL rst_issue_async: req %b val %b rdy %b want 0", reqs(), rsp_val, cmd_rdy); end
    vectors++; if (occupancy !== 6'd0 || proto_err !== 1'b0) begin miscompares++; $display("FAIL rst_issue_occ: occ %0d perr %b want 0 0", occupancy, proto_err); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (cmd_rdy !== 1'b1 || rsp_val !== 1'b0 || reqs() !== 4'b0000) begin miscompares++; $display("FAIL rst_issue_release: rdy %b val %b req %b want 1 0 0000", cmd_rdy, rsp_val, reqs()); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    cmd_val = 1'b0; cmd_op = 2'd0; cmd_data = 32'h0;
    rsp_rdy = 1'b1;
    enq_back_cpl = 1'b0; enq_front_cpl = 1'b0; deq_front_cpl = 1'b0; deq_back_cpl = 1'b0;
    deq_front_data = 32'h0; deq_back_data = 32'h0;
    test_reset();
    test_enq_back();
    test_deq_front();
    test_timeout();
    test_proto_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
